transmit_buffer: RTL

- FIFO-buffered UART transmitter, the outbound counterpart of the serial receiver path.
- Producer logic pushes bytes with a stb/rdy handshake. The block queues them and serializes each one on txd as 8N1, LSB first.
- Frames go out back-to-back, so bursty producers never wait on the baud period.
- Sits between core logic and the board TX pin; pairs with receive for full-duplex links.

---
 rtl/transmit_buffer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/transmit_buffer.sv
// FIFO-buffered 8N1 UART transmitter: queued bytes are shifted out LSB first on txd,
// frames are sent back-to-back while the FIFO holds data.
module transmit_buffer #(
  parameter real         BAUDRATE  = 96e2,
  parameter real         FREQUENCY = 12e6,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stb,
  input  logic [7:0]                 dat,
  output logic                       rdy,
  output logic                       txd,
  output logic                       bsy,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);

  localparam int unsigned CYCLES = $rtoi(FREQUENCY / BAUDRATE);
  localparam int unsigned CW     = $clog2(DEPTH + 1);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned TW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [TW-1:0] TOP  = TW'(CYCLES - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    shift, shift_nx;
  logic [2:0]    idx, idx_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [CW-1:0] cnt_nx;
  logic          push, pop, txd_nx;

  assign push = stb && rdy;

  always_comb begin
    state_nx = state;
    shift_nx = shift;
    idx_nx   = idx;
    timer_nx = timer;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (cnt != '0) begin
          pop      = 1'b1;
          shift_nx = mem[rd_ptr];
          timer_nx = TOP;
          state_nx = START;
        end
      end
      START: begin
        if (timer == '0) begin
          timer_nx = TOP;
          idx_nx   = '0;
          state_nx = DATA;
        end else begin
          timer_nx = timer - TW'(1);
        end
      end
      DATA: begin
        if (timer == '0) begin
          timer_nx = TOP;
          shift_nx = {1'b0, shift[7:1]};
          if (idx == 3'd7) state_nx = STOP;
          else             idx_nx   = idx + 3'd1;
        end else begin
          timer_nx = timer - TW'(1);
        end
      end
      default: begin
        // STOP chains straight into the next START when data is waiting
        if (timer == '0) begin
          if (cnt != '0) begin
            pop      = 1'b1;
            shift_nx = mem[rd_ptr];
            timer_nx = TOP;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          timer_nx = timer - TW'(1);
        end
      end
    endcase
  end

  always_comb begin
    cnt_nx = cnt + CW'(push) - CW'(pop);
    case (state)
      START:   txd_nx = 1'b0;
      DATA:    txd_nx = shift[0];
      default: txd_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shift  <= '0;
      idx    <= '0;
      timer  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rdy    <= 1'b1;
      txd    <= 1'b1;
      bsy    <= 1'b0;
    end else begin
      state  <= state_nx;
      shift  <= shift_nx;
      idx    <= idx_nx;
      timer  <= timer_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt    <= cnt_nx;
      rdy    <= (cnt_nx < FULL);
      txd    <= txd_nx;
      bsy    <= (state != IDLE) || (cnt != '0);
    end
  end

endmodule
